// File: rtl/int_prio_sched_if.sv
// int_prio_sched_if: source/mask/priority inputs, CPU handshake and request/clear outputs of the scheduler
interface int_prio_sched_if #(
  parameter int NSRC = 8,
  parameter int IW = $clog2(NSRC)
);
  logic [NSRC-1:0] int_pend;
  logic [NSRC-1:0] int_mask;
  logic [2*NSRC-1:0] prio_cfg;
  logic ack;
  logic eoi;
  logic err_clr;
  logic irq_o;
  logic [IW-1:0] cand_id;
  logic [IW-1:0] vec_id;
  logic vec_vld;
  logic [NSRC-1:0] clr_o;
  logic spur_o;
  logic err_o;
  modport master (
    output int_pend, int_mask, prio_cfg, ack, eoi, err_clr,
    input irq_o, cand_id, vec_id, vec_vld, clr_o, spur_o, err_o
  );
  modport slave (
    input int_pend, int_mask, prio_cfg, ack, eoi, err_clr,
    output irq_o, cand_id, vec_id, vec_vld, clr_o, spur_o, err_o
  );
endinterface

// File: rtl/int_prio_sched.sv
// int_prio_sched: masked priority arbitration, ack/EOI handshake with clear pulse and in-service watchdog.
// Define INT_SCHED_RR_EN for round-robin tie-break among equal top priorities.
module int_prio_sched #(
  parameter int NSRC = 8,
  parameter int WDT_W = 10
) (
  input logic clk,
  input logic rst,
  int_prio_sched_if.slave bus
);
  localparam int IW = $clog2(NSRC);
  localparam logic [WDT_W-1:0] wdt_last = {{(WDT_W-1){1'b1}}, 1'b0};
  typedef enum logic [1:0] {IDLE, REQ, INSVC} state_t;
  state_t state, state_d;
  logic [NSRC-1:0] elig, tie, clr_d;
  logic [1:0] pmax;
  logic [IW-1:0] win, cand_d, vec_d;
  logic win_vld, found, acc, tmo, irq_d, vld_d, spur_d, err_d;
  logic [WDT_W-1:0] wdt, wdt_d;
`ifdef INT_SCHED_RR_EN
  logic [IW-1:0] rr_ptr;
`endif
  assign elig = bus.int_pend & ~bus.int_mask;
  assign win_vld = |elig;
  always_comb begin
    pmax = '0;
    for (int i = 0; i < NSRC; i++)
      if (elig[i] && bus.prio_cfg[2*i +: 2] > pmax) pmax = bus.prio_cfg[2*i +: 2];
    for (int i = 0; i < NSRC; i++)
      tie[i] = elig[i] && bus.prio_cfg[2*i +: 2] == pmax;
    found = 1'b0;
    win = '0;
`ifdef INT_SCHED_RR_EN
    for (int k = 1; k <= NSRC; k++) begin
      int j = (int'(rr_ptr) + k) % NSRC;
      if (!found && tie[j]) begin
        win = IW'(j);
        found = 1'b1;
      end
    end
`else
    for (int i = 0; i < NSRC; i++)
      if (!found && tie[i]) begin
        win = IW'(i);
        found = 1'b1;
      end
`endif
  end
  assign acc = state == REQ && bus.ack;
  // eoi on the timeout cycle suppresses the error
  assign tmo = state == INSVC && !bus.eoi && wdt == wdt_last;
  always_comb
    state_d = state == IDLE ? (win_vld ? REQ : IDLE)
            : state == REQ ? (bus.ack ? INSVC : win_vld ? REQ : IDLE)
            : (bus.eoi || tmo) ? IDLE : INSVC;
  always_comb begin
    irq_d = state_d == REQ;
    cand_d = state_d == REQ ? win : bus.cand_id;
    vec_d = acc ? bus.cand_id : bus.vec_id;
    vld_d = state_d == INSVC;
    clr_d = acc ? NSRC'(1) << bus.cand_id : '0;
    spur_d = bus.ack && state != REQ;
    wdt_d = acc ? '0 : state == INSVC ? wdt + 1'b1 : wdt;
    err_d = tmo | (bus.err_o & ~bus.err_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.irq_o <= 1'b0;
      bus.cand_id <= '0;
      bus.vec_id <= '0;
      bus.vec_vld <= 1'b0;
      bus.clr_o <= '0;
      bus.spur_o <= 1'b0;
      bus.err_o <= 1'b0;
      wdt <= '0;
    end else begin
      state <= state_d;
      bus.irq_o <= irq_d;
      bus.cand_id <= cand_d;
      bus.vec_id <= vec_d;
      bus.vec_vld <= vld_d;
      bus.clr_o <= clr_d;
      bus.spur_o <= spur_d;
      bus.err_o <= err_d;
      wdt <= wdt_d;
    end
  end
`ifdef INT_SCHED_RR_EN
  always_ff @(posedge clk)
    if (rst) rr_ptr <= IW'(NSRC - 1);
    else if (acc) rr_ptr <= bus.cand_id;
`endif
endmodule

// File: tb/tb_int_prio_sched.sv
// tb_int_prio_sched: directed vector table plus watchdog and tie-break sequences for int_prio_sched (WDT_W = 4)
module tb_int_prio_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int_prio_sched_if bus ();
  int_prio_sched #(.NSRC(8), .WDT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    string name;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [15:0] prio;
    logic ack;
    logic eoi;
    logic [17:0] exp;
  } vec_t;
  vec_t tv[$];
  int n_run = 0;
  int n_fail = 0;
  int exp_rr[3];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [17:0] outs;
    return {bus.irq_o, bus.cand_id, bus.vec_id, bus.vec_vld, bus.clr_o, bus.spur_o, bus.err_o};
  endfunction
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic add(input string n, input logic [7:0] pend, input logic [7:0] mask, input logic [15:0] prio,
                     input logic ack, input logic eoi, input logic irq, input logic [2:0] cand,
                     input logic [2:0] vec, input logic vld, input logic [7:0] clr, input logic spur);
    vec_t v;
    v.name = n; v.pend = pend; v.mask = mask; v.prio = prio; v.ack = ack; v.eoi = eoi;
    v.exp = {irq, cand, vec, vld, clr, spur, 1'b0};
    tv.push_back(v);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.int_pend = '0; bus.int_mask = '0; bus.prio_cfg = '0;
    bus.ack = 0; bus.eoi = 0; bus.err_clr = 0;
    tick; tick;
    check("reset", 32'(outs()), 0);
    rst = 0;
    //  name               pend   mask   prio      ack eoi irq cand vec vld clr    spur
    add("single_req",      8'h08, 8'h00, 16'h0000, 0, 0, 1, 3, 0, 0, 8'h00, 0);
    add("single_ack",      8'h08, 8'h00, 16'h0000, 1, 0, 0, 3, 3, 1, 8'h08, 0);
    add("clr_one_cycle",   8'h00, 8'h00, 16'h0000, 0, 0, 0, 3, 3, 1, 8'h00, 0);
    add("single_eoi",      8'h00, 8'h00, 16'h0000, 0, 1, 0, 3, 3, 0, 8'h00, 0);
    add("idle_quiet",      8'h00, 8'h00, 16'h0000, 0, 0, 0, 3, 3, 0, 8'h00, 0);
    add("p1_req",          8'h02, 8'h00, 16'h3004, 0, 0, 1, 1, 3, 0, 8'h00, 0);
    add("p6_preempt",      8'h42, 8'h00, 16'h3004, 0, 0, 1, 6, 3, 0, 8'h00, 0);
    add("p6_ack",          8'h42, 8'h00, 16'h3004, 1, 0, 0, 6, 6, 1, 8'h40, 0);
    add("p6_clr_drop",     8'h02, 8'h00, 16'h3004, 0, 0, 0, 6, 6, 1, 8'h00, 0);
    add("insvc_spur",      8'h02, 8'h00, 16'h3004, 1, 0, 0, 6, 6, 1, 8'h00, 1);
    add("spur_one_cycle",  8'h02, 8'h00, 16'h3004, 0, 0, 0, 6, 6, 1, 8'h00, 0);
    add("p6_eoi",          8'h02, 8'h00, 16'h3004, 0, 1, 0, 6, 6, 0, 8'h00, 0);
    add("p1_rereq",        8'h02, 8'h00, 16'h3004, 0, 0, 1, 1, 6, 0, 8'h00, 0);
    add("withdraw",        8'h00, 8'h00, 16'h3004, 0, 0, 0, 1, 6, 0, 8'h00, 0);
    add("masked",          8'h01, 8'h01, 16'h3004, 0, 0, 0, 1, 6, 0, 8'h00, 0);
    add("unmasked",        8'h01, 8'h00, 16'h3004, 0, 0, 1, 0, 6, 0, 8'h00, 0);
    add("withdraw0",       8'h00, 8'h00, 16'h3004, 0, 0, 0, 0, 6, 0, 8'h00, 0);
    add("idle_spur",       8'h00, 8'h00, 16'h3004, 1, 0, 0, 0, 6, 0, 8'h00, 1);
    add("idle_spur_end",   8'h00, 8'h00, 16'h3004, 0, 0, 0, 0, 6, 0, 8'h00, 0);
    add("idle_eoi_ignore", 8'h00, 8'h00, 16'h3004, 0, 1, 0, 0, 6, 0, 8'h00, 0);
    add("req_again",       8'h01, 8'h00, 16'h3004, 0, 0, 1, 0, 6, 0, 8'h00, 0);
    add("ack_over_wdraw",  8'h00, 8'h00, 16'h3004, 1, 0, 0, 0, 0, 1, 8'h01, 0);
    add("ack_clr_end",     8'h00, 8'h00, 16'h3004, 0, 0, 0, 0, 0, 1, 8'h00, 0);
    add("ack_eoi",         8'h00, 8'h00, 16'h3004, 0, 1, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < tv.size(); i++) begin
      bus.int_pend = tv[i].pend; bus.int_mask = tv[i].mask; bus.prio_cfg = tv[i].prio;
      bus.ack = tv[i].ack; bus.eoi = tv[i].eoi;
      tick;
      check(tv[i].name, 32'(outs()), 32'(tv[i].exp));
    end
    bus.ack = 0; bus.eoi = 0;
    // watchdog timeout: 15 cycles in service without eoi
    bus.int_pend = 8'h10;
    tick;
    check("wdt_req", 32'(bus.irq_o), 1);
    bus.ack = 1; tick; bus.ack = 0; bus.int_pend = 0;
    check("wdt_insvc", 32'({bus.vec_vld, bus.vec_id}), 32'({1'b1, 3'd4}));
    repeat (14) tick;
    check("wdt_before", 32'({bus.vec_vld, bus.err_o}), 2'b10);
    tick;
    check("wdt_timeout", 32'({bus.irq_o, bus.vec_vld, bus.err_o, bus.clr_o}), 32'({3'b001, 8'h00}));
    tick;
    check("wdt_err_sticky", 32'(bus.err_o), 1);
    bus.err_clr = 1; tick; bus.err_clr = 0;
    check("wdt_err_clr", 32'(bus.err_o), 0);
    // eoi on the timeout cycle wins
    bus.int_pend = 8'h10; tick;
    bus.ack = 1; tick; bus.ack = 0; bus.int_pend = 0;
    repeat (14) tick;
    bus.eoi = 1; tick; bus.eoi = 0;
    check("wdt_eoi_wins", 32'({bus.vec_vld, bus.err_o}), 2'b00);
    tick;
    check("wdt_eoi_no_err", 32'(bus.err_o), 0);
    // tie-break between sources 2 and 5, both priority 2
`ifdef INT_SCHED_RR_EN
    exp_rr = '{2, 5, 2};
`else
    exp_rr = '{2, 2, 2};
`endif
    rst = 1; tick; rst = 0;
    check("rst_mid", 32'(outs()), 0);
    bus.prio_cfg = 16'h0820; bus.int_pend = 8'h24; bus.int_mask = 0;
    for (int r = 0; r < 3; r++) begin
      tick;
      check($sformatf("tie_irq%0d", r), 32'({bus.irq_o, bus.cand_id}), 32'({1'b1, 3'(exp_rr[r])}));
      bus.ack = 1; tick; bus.ack = 0;
      check($sformatf("tie_vec%0d", r), 32'({bus.vec_vld, bus.vec_id, bus.clr_o}),
            32'({1'b1, 3'(exp_rr[r]), 8'(8'h01 << exp_rr[r])}));
      bus.eoi = 1; tick; bus.eoi = 0;
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
